// File: rtl/async_fifo_wr_side_if.sv
// Write-side FIFO bus: client request/clear and read-domain Gray pointer in; memory write port and status out.
// slave = write controller, master = the client/memory/read-side environment that drives it.
interface async_fifo_wr_side_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  w_request_in;
    logic                  w_overflow_clr_in;
    logic [ADDR_WIDTH:0]   r_gptr_in;
    logic                  w_en_out;
    logic [ADDR_WIDTH-1:0] w_addr_out;
    logic [ADDR_WIDTH:0]   w_gptr_out;
    logic                  w_full_out;
    logic                  w_almost_full_out;
    logic [ADDR_WIDTH:0]   w_level_out;
    logic                  w_overflow_out;

    modport slave (
        input  w_request_in, w_overflow_clr_in, r_gptr_in,
        output w_en_out, w_addr_out, w_gptr_out, w_full_out,
               w_almost_full_out, w_level_out, w_overflow_out
    );

    modport master (
        output w_request_in, w_overflow_clr_in, r_gptr_in,
        input  w_en_out, w_addr_out, w_gptr_out, w_full_out,
               w_almost_full_out, w_level_out, w_overflow_out
    );
endinterface

// File: rtl/async_fifo_wr_side.sv
// Write-domain controller of an async FIFO: pointers, read-pointer synchroniser, full/level/overflow status.
// Write commits on the edge where w_en_out=1 and status reflects it right after; requests while full are dropped and flagged.
module async_fifo_wr_side #(
    parameter int ADDR_WIDTH   = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AF_THRESHOLD = 6
) (
    input  logic                  w_clk_in,
    input  logic                  w_reset_n_in,
    async_fifo_wr_side_if.slave   bus
);
    localparam int PW = ADDR_WIDTH + 1;
    // Inverting the top two Gray bits of the read pointer gives the write pointer one lap ahead.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] sync_d [SYNC_STAGES];
    logic          ovf_q, ovf_d;

    logic [PW-1:0] rg_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level;
    logic [PW-1:0] wbin_inc;
    logic          full;
    logic          w_en;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    always_comb begin
        rg_s     = sync_q[SYNC_STAGES-1];
        rbin_s   = gray2bin(rg_s);
        level    = wbin_q - rbin_s;
        full     = (wgray_q == (rg_s ^ FULL_MASK));
        w_en     = bus.w_request_in & ~full & w_reset_n_in;
        wbin_inc = wbin_q + PW'(1);

        wbin_d  = wbin_q;
        wgray_d = wgray_q;
        if (w_en) begin
            wbin_d  = wbin_inc;
            wgray_d = bin2gray(wbin_inc);
        end

        sync_d[0] = bus.r_gptr_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        // A dropped request on the same edge as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (bus.w_request_in && full) begin
            ovf_d = 1'b1;
        end else if (bus.w_overflow_clr_in) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge w_clk_in or negedge w_reset_n_in) begin
        if (!w_reset_n_in) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign bus.w_en_out          = w_en;
    assign bus.w_addr_out        = wbin_q[ADDR_WIDTH-1:0];
    assign bus.w_gptr_out        = wgray_q;
    assign bus.w_full_out        = full;
    assign bus.w_almost_full_out = (32'(level) >= AF_THRESHOLD);
    assign bus.w_level_out       = level;
    assign bus.w_overflow_out    = ovf_q;
endmodule

// File: tb/tb_async_fifo_wr_side.sv
// Vector table plus scoreboard bench for async_fifo_wr_side with ADDR_WIDTH=3, SYNC_STAGES=2, AF_THRESHOLD=6.
module tb_async_fifo_wr_side;
    logic w_clk_in;
    logic w_reset_n_in;

    async_fifo_wr_side_if #(.ADDR_WIDTH(3)) bus ();

    async_fifo_wr_side #(
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (2),
        .AF_THRESHOLD(6)
    ) dut (
        .w_clk_in    (w_clk_in),
        .w_reset_n_in(w_reset_n_in),
        .bus         (bus)
    );

    initial w_clk_in = 1'b0;
    always #5 w_clk_in = ~w_clk_in;

    typedef struct {
        logic       req;
        logic       clr;
        logic [3:0] rg;
        logic       en;     // expected before the edge
        logic [2:0] addr;   // remaining fields expected after the edge
        logic [3:0] gptr;
        logic       full;
        logic       af;
        logic [3:0] level;
        logic       ovf;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl [16];
    vec_t sb_q [$];
    logic [3:0] gray_tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        check({tag, ".addr"},  32'(bus.w_addr_out),        32'(e.addr));
        check({tag, ".gptr"},  32'(bus.w_gptr_out),        32'(e.gptr));
        check({tag, ".full"},  32'(bus.w_full_out),        32'(e.full));
        check({tag, ".af"},    32'(bus.w_almost_full_out), 32'(e.af));
        check({tag, ".level"}, 32'(bus.w_level_out),       32'(e.level));
        check({tag, ".ovf"},   32'(bus.w_overflow_out),    32'(e.ovf));
    endtask

    // Called just after a falling edge: drive, check w_en_out, clock, then score the popped expectation.
    task automatic apply_vec(input string tag, input vec_t v);
        vec_t e;
        bus.w_request_in      = v.req;
        bus.w_overflow_clr_in = v.clr;
        bus.r_gptr_in         = v.rg;
        #1;
        check({tag, ".en"}, 32'(bus.w_en_out), 32'(v.en));
        sb_q.push_back(v);
        @(posedge w_clk_in);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_outputs(tag, e);
        end
        @(negedge w_clk_in);
    endtask

    task automatic do_reset();
        w_reset_n_in          = 1'b0;
        bus.w_request_in      = 1'b0;
        bus.w_overflow_clr_in = 1'b0;
        bus.r_gptr_in         = 4'd0;
        @(negedge w_clk_in);
        @(negedge w_clk_in);
        w_reset_n_in = 1'b1;
    endtask

    initial begin
        vec_t rv;
        vec_t z;

        gray_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        //            req   clr   rg       en    addr  gptr     full  af    lvl   ovf
        tbl[0]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd2, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd3, 4'b0010, 1'b0, 1'b0, 4'd3, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd4, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd5, 4'b0111, 1'b0, 1'b0, 4'd5, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd6, 4'b0101, 1'b0, 1'b1, 4'd6, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd7, 4'b0100, 1'b0, 1'b1, 4'd7, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 4'b0010, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 4'b0010, 1'b0, 3'd0, 4'b1100, 1'b0, 1'b0, 4'd5, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 4'b0010, 1'b1, 3'd1, 4'b1101, 1'b0, 1'b1, 4'd6, 1'b0};

        z = '{1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0};

        // Reset state, with a request held to confirm the write enable is gated.
        w_reset_n_in          = 1'b0;
        bus.w_request_in      = 1'b1;
        bus.w_overflow_clr_in = 1'b0;
        bus.r_gptr_in         = 4'd0;
        #3;
        check("reset.en", 32'(bus.w_en_out), 32'd0);
        check_outputs("reset", z);
        do_reset();

        // Five writes, then asynchronous reset between edges.
        for (int i = 0; i < 5; i++) apply_vec($sformatf("pre_rst[%0d]", i), tbl[i]);
        bus.w_request_in = 1'b1;
        #2;
        w_reset_n_in = 1'b0;
        #1;
        check("async_rst.en", 32'(bus.w_en_out), 32'd0);
        check_outputs("async_rst", z);
        do_reset();

        // Fill, overflow set/clear, synchronised drain.
        for (int i = 0; i < 16; i++) apply_vec($sformatf("tbl[%0d]", i), tbl[i]);

        // Wrap: read pointer trails the write pointer by two writes at the input.
        do_reset();
        for (int j = 1; j <= 20; j++) begin
            int rd;
            rd = (j - 3 > 0) ? j - 3 : 0;
            rv.req   = 1'b1;
            rv.clr   = 1'b0;
            rv.rg    = gray_tbl[rd % 16];
            rv.en    = 1'b1;
            rv.addr  = 3'(j % 8);
            rv.gptr  = gray_tbl[j % 16];
            rv.full  = 1'b0;
            rv.af    = 1'b0;
            rv.level = 4'(j - ((j - 4 > 0) ? j - 4 : 0));
            rv.ovf   = 1'b0;
            apply_vec($sformatf("wrap[%0d]", j), rv);
            if (j == 15) check("wrap.gptr_pre", 32'(bus.w_gptr_out), 32'h8);
            if (j == 16) check("wrap.gptr_post", 32'(bus.w_gptr_out), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
